tart_readback: RTL and testbench
================================

Name: tart_readback

Overview:
Parametrised successor to the acquisition read-back slave on the SPI-bridged Wishbone-like bus. It prefetches SAMPLE-bit acquisition samples from the DRAM/sample source into a DEPTH-entry FIFO. Each sample is served as SAMPLE/WIDTH bus words, MSB-first. Burst reads are supported with wait-state insertion, and control/status registers are exposed in a 4-word window.

Parameters:
WIDTH, 8, bus data width (bits)
SAMPLE, 24, sample width; SAMPLE % WIDTH == 0 is required (elaboration error otherwise)
DEPTH, 4, prefetch FIFO entries; power of two, at least 2
ABITS, 2, log2(DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
cyc_i  in  1  bus cycle
stb_i  in  1  strobe (block-select already decoded)
we_i  in  1  write enable
bst_i  in  1  burst in progress
ack_o  out  1  transfer acknowledge
wat_o  out  1  wait; slave not ready this cycle
adr_i  in  2  register address
dat_i  in  WIDTH  write data
dat_o  out  WIDTH  read data
data_ready  in  1  data_in valid this cycle
data_request  out  1  one-cycle pulse requesting the next sample
data_in  in  SAMPLE  sample from the source
spi_busy  in  1  SPI transaction active
aq_enabled  out  1  acquisition enable
aq_debug_mode  out  1  debug mode
aq_sample_delay  out  3  sample delay

Behaviour:
- Reset: ack_o=0, wat_o=0, dat_o=0, data_request=0, control=0, FIFO empty, byte index=0, outstanding=0, underrun=0.
- Register map:
  - 0 DATA (R): next byte of the head sample.
  - 1 LEVEL (R): FIFO count, zero-extended.
  - 2 STATUS (R/W1C): bit0 empty, bit1 full, bit2 underrun (sticky; write 1 to clear), bit7 spi_busy.
  - 3 CONTROL (R/W): bit0 enable, bit1 debug, bits[4:2] sample_delay. The outputs drive directly from this register.
- Handshake:
  - A request is a cycle with cyc_i&&stb_i&&!ack_o.
  - ack_o rises one cycle after the request and stays high for exactly one cycle. dat_o is valid in the ack cycle.
  - With bst_i held, a new request may be presented the cycle after ack_o; throughput is one word per 2 cycles.
  - ack_o is forced low whenever cyc_i=0.
- Wait states: on a DATA read with the FIFO empty and enable=1, wat_o is high and ack is withheld until a sample is written. ack_o then follows one cycle after the write.
- DATA read with FIFO empty and enable=0: immediate ack, dat_o=0, underrun set.
- Byte serialisation:
  - byte index b in 0..SAMPLE/WIDTH-1; dat_o = head[SAMPLE-1-b*WIDTH -: WIDTH].
  - On a DATA ack, b increments. The ack at the last b pops the FIFO and wraps b to 0.
- Prefetch:
  - data_request pulses when enable=1, outstanding=0, and count<DEPTH. outstanding is then set.
  - data_ready while outstanding pushes data_in and clears outstanding. data_ready while not outstanding is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full FIFO: no requests are issued.
- Clearing enable (write CONTROL bit0=0): FIFO flushed, b=0, outstanding cleared, and a late data_ready is ignored. This takes effect in the ack cycle.
- Writes to DATA/LEVEL: acked and ignored. Reads of CONTROL return bits[4:0], upper bits 0.
- rst mid-burst: all state returns to reset values on the next edge; no ack issued for the aborted request.

Decomposition:
- Package tart_readback_pkg: register address constants (ADR_DATA=0, ADR_LEVEL=1, ADR_STATUS=2, ADR_CONTROL=3) and STATUS/CONTROL bit-position constants.
- Sub-module tart_sample_fifo: DEPTH x SAMPLE synchronous FIFO with push, pop, flush, count, empty, full, and a combinational head output.

Test Plan:
- Reset, then read CONTROL and STATUS -> 0x00 and 0x01 (empty); no data_request observed.
- Write CONTROL=0x01; source returns 0xA1B2C3, 0x445566 (data_ready one cycle after request) -> exactly one request outstanding at a time; LEVEL=2 until DEPTH=4, then no further requests; STATUS bit1=1.
- Burst read 6 words from DATA -> A1,B2,C3,44,55,66 in order; ack one cycle after each strobe; count falls after every third byte.
- DATA read while FIFO empty and enabled -> wat_o high until data_ready; ack exactly one cycle after the push; correct MSB byte returned.
- Write CONTROL=0x00 with 3 samples buffered, then read DATA -> LEVEL=0, dat_o=0x00, STATUS bit2=1; write STATUS=0x04 -> bit2 clears.
- Assert rst during a burst with b=1 -> ack_o low next cycle, LEVEL=0, b=0; re-enable and the first byte read is the MSB of a new sample.

Source files
------------

// File: rtl/tart_readback_pkg.sv
// Shared register map and bit positions for the acquisition read-back slave.
package tart_readback_pkg;

    localparam logic [1:0] ADR_DATA    = 2'd0;
    localparam logic [1:0] ADR_LEVEL   = 2'd1;
    localparam logic [1:0] ADR_STATUS  = 2'd2;
    localparam logic [1:0] ADR_CONTROL = 2'd3;

    localparam int unsigned ST_EMPTY    = 0;
    localparam int unsigned ST_FULL     = 1;
    localparam int unsigned ST_UNDERRUN = 2;
    localparam int unsigned ST_SPI_BUSY = 7;

    localparam int unsigned CTL_EN      = 0;
    localparam int unsigned CTL_DEBUG   = 1;
    localparam int unsigned CTL_DLY_LSB = 2;
    localparam int unsigned CTL_DLY_MSB = 4;
    localparam int unsigned CTL_BITS    = 5;

endpackage

// File: rtl/tart_sample_fifo.sv
// DEPTH x SAMPLE synchronous prefetch FIFO; head is the oldest entry, visible combinationally.
module tart_sample_fifo
    import tart_readback_pkg::*;
#(
    parameter int unsigned SAMPLE = 24,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ABITS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [SAMPLE-1:0] din,
    input  logic              pop,
    input  logic              flush,
    output logic [SAMPLE-1:0] head_c,
    output logic [ABITS:0]    count,
    output logic              empty_c,
    output logic              full_c
);
    localparam int unsigned CW = ABITS + 1;

    logic [SAMPLE-1:0] mem [DEPTH];
    logic [ABITS-1:0]  wr_ptr;
    logic [ABITS-1:0]  rd_ptr;

    // Storage carries no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ABITS'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ABITS'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head_c  = mem[rd_ptr];
    assign empty_c = (count == '0);
    assign full_c  = (count == CW'(DEPTH));

endmodule

// File: rtl/tart_readback.sv
// Acquisition read-back slave: prefetches samples into a FIFO and serves them MSB-first as bus words.
module tart_readback
    import tart_readback_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned SAMPLE = 24,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ABITS  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cyc_i,
    input  logic              stb_i,
    input  logic              we_i,
    input  logic              bst_i,
    output logic              ack_o,
    output logic              wat_o,
    input  logic [1:0]        adr_i,
    input  logic [WIDTH-1:0]  dat_i,
    output logic [WIDTH-1:0]  dat_o,
    input  logic              data_ready,
    output logic              data_request,
    input  logic [SAMPLE-1:0] data_in,
    input  logic              spi_busy,
    output logic              aq_enabled,
    output logic              aq_debug_mode,
    output logic [2:0]        aq_sample_delay
);
    localparam int unsigned WORDS = SAMPLE / WIDTH;
    localparam int unsigned BW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned CW    = ABITS + 1;

    if (SAMPLE % WIDTH != 0) begin : g_bad_sample
        $error("tart_readback: SAMPLE must be a multiple of WIDTH");
    end
    if (DEPTH < 2 || (1 << ABITS) != DEPTH) begin : g_bad_depth
        $error("tart_readback: DEPTH must be a power of two >= 2 and equal 2**ABITS");
    end
    if (WIDTH < 8) begin : g_bad_width
        $error("tart_readback: WIDTH must be at least 8");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t              state;
    state_t              state_nx;
    logic [CTL_BITS-1:0] ctl;
    logic                underrun;
    logic                outstanding;
    logic [BW-1:0]       bidx;

    logic [SAMPLE-1:0]   fifo_head;
    logic [CW-1:0]       fifo_count;
    logic                fifo_empty;
    logic                fifo_full;

    logic                req;
    logic                accept;
    logic                is_data_rd;
    logic                push_now;
    logic                stall;
    logic                data_rd;
    logic                rd_underrun;
    logic                last_word;
    logic                do_pop;
    logic                ctl_wr;
    logic                disable_now;
    logic                bypass;
    logic [SAMPLE-1:0]   head_src;
    logic [WIDTH-1:0]    word_sel;
    logic [WIDTH-1:0]    rdata;
    logic                unused_ok;

    assign req         = cyc_i && stb_i && !ack_o;
    assign is_data_rd  = !we_i && (adr_i == ADR_DATA);
    assign push_now    = data_ready && outstanding;
    assign stall       = is_data_rd && fifo_empty && ctl[CTL_EN] && !push_now;
    assign data_rd     = accept && is_data_rd;
    assign rd_underrun = fifo_empty && !push_now;
    assign last_word   = (bidx == BW'(WORDS - 1));
    assign do_pop      = data_rd && !rd_underrun && last_word;
    assign ctl_wr      = accept && we_i && (adr_i == ADR_CONTROL);
    assign disable_now = ctl_wr && !dat_i[CTL_EN];
    // A sample arriving into an empty FIFO can be consumed whole in the same cycle.
    assign bypass      = fifo_empty && push_now && do_pop;
    assign head_src    = fifo_empty ? data_in : fifo_head;

    // Bus handshake: request, optional wait, single-cycle ack.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_WAIT: begin
                if (!req) begin
                    state_nx = S_IDLE;
                end else if (stall) begin
                    state_nx = S_WAIT;
                end else begin
                    state_nx = S_ACK;
                    accept   = 1'b1;
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        word_sel = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (BW'(i) == bidx) begin
                word_sel = head_src[SAMPLE-1-i*WIDTH -: WIDTH];
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (adr_i)
            ADR_DATA:  rdata = rd_underrun ? '0 : word_sel;
            ADR_LEVEL: rdata = WIDTH'(fifo_count);
            ADR_STATUS: begin
                rdata[ST_EMPTY]    = fifo_empty;
                rdata[ST_FULL]     = fifo_full;
                rdata[ST_UNDERRUN] = underrun;
                rdata[ST_SPI_BUSY] = spi_busy;
            end
            default:   rdata = WIDTH'(ctl);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            dat_o        <= '0;
            ctl          <= '0;
            underrun     <= 1'b0;
            outstanding  <= 1'b0;
            bidx         <= '0;
            data_request <= 1'b0;
        end else begin
            state        <= state_nx;
            data_request <= 1'b0;
            if (accept) begin
                dat_o <= we_i ? '0 : rdata;
            end
            if (data_rd) begin
                if (rd_underrun) begin
                    underrun <= 1'b1;
                end else begin
                    bidx <= last_word ? '0 : bidx + BW'(1);
                end
            end
            if (accept && we_i && (adr_i == ADR_STATUS) && dat_i[ST_UNDERRUN]) begin
                underrun <= 1'b0;
            end
            if (ctl_wr) begin
                ctl <= dat_i[CTL_BITS-1:0];
            end
            // One sample in flight at a time; never request into a full FIFO.
            if (push_now) begin
                outstanding <= 1'b0;
            end else if (ctl[CTL_EN] && !outstanding && !fifo_full && !disable_now) begin
                data_request <= 1'b1;
                outstanding  <= 1'b1;
            end
            if (disable_now) begin
                bidx        <= '0;
                outstanding <= 1'b0;
            end
        end
    end

    tart_sample_fifo #(
        .SAMPLE (SAMPLE),
        .DEPTH  (DEPTH),
        .ABITS  (ABITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_now && !bypass),
        .din     (data_in),
        .pop     (do_pop && !bypass),
        .flush   (disable_now),
        .head_c  (fifo_head),
        .count   (fifo_count),
        .empty_c (fifo_empty),
        .full_c  (fifo_full)
    );

    assign ack_o           = (state == S_ACK) && cyc_i;
    assign wat_o           = (state == S_WAIT);
    assign aq_enabled      = ctl[CTL_EN];
    assign aq_debug_mode   = ctl[CTL_DEBUG];
    assign aq_sample_delay = ctl[CTL_DLY_MSB:CTL_DLY_LSB];

    assign unused_ok = ^{bst_i, dat_i[WIDTH-1:CTL_BITS]};

endmodule

// File: tb/tb_tart_readback.sv
// Directed bench for tart_readback: register access, prefetch, burst serialisation, wait states, flush, reset.
module tb_tart_readback;
    import tart_readback_pkg::*;

    logic        clk;
    logic        rst;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic        bst_i;
    logic        ack_o;
    logic        wat_o;
    logic [1:0]  adr_i;
    logic [7:0]  dat_i;
    logic [7:0]  dat_o;
    logic        data_ready;
    logic        data_request;
    logic [23:0] data_in;
    logic        spi_busy;
    logic        aq_enabled;
    logic        aq_debug_mode;
    logic [2:0]  aq_sample_delay;

    int checks = 0;
    int errors = 0;

    // Source model state
    logic [23:0] samples [10] = '{24'hA1B2C3, 24'h445566, 24'h778899, 24'hAABBCC, 24'h123456,
                                  24'h789ABC, 24'hDEF012, 24'h345678, 24'hBCDEF0, 24'h9ABCDE};
    logic src_gate = 1'b0;
    logic pend     = 1'b0;
    int   delivered = 0;
    int   req_cnt   = 0;
    int   overlap   = 0;

    tart_readback dut (
        .clk             (clk),
        .rst             (rst),
        .cyc_i           (cyc_i),
        .stb_i           (stb_i),
        .we_i            (we_i),
        .bst_i           (bst_i),
        .ack_o           (ack_o),
        .wat_o           (wat_o),
        .adr_i           (adr_i),
        .dat_i           (dat_i),
        .dat_o           (dat_o),
        .data_ready      (data_ready),
        .data_request    (data_request),
        .data_in         (data_in),
        .spi_busy        (spi_busy),
        .aq_enabled      (aq_enabled),
        .aq_debug_mode   (aq_debug_mode),
        .aq_sample_delay (aq_sample_delay)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Sample source: answers a request with data_ready one cycle later when gated on.
    initial begin
        data_ready = 1'b0;
        data_in    = '0;
        forever begin
            @(negedge clk);
            data_ready = 1'b0;
            if (!aq_enabled) begin
                pend = 1'b0;
            end else if (pend && src_gate) begin
                data_in    = (delivered < 10) ? samples[delivered[3:0]] : 24'h0;
                data_ready = 1'b1;
                pend       = 1'b0;
                delivered++;
            end
            if (data_request) begin
                if (pend) overlap++;
                pend = 1'b1;
                req_cnt++;
            end
        end
    end

    task automatic report(input string tag, input logic ok, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic w, input logic [1:0] a, input logic [7:0] wd,
                       output logic [7:0] rd, output int lat);
        tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = wd;
        lat = -1;
        rd  = '0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ack_o) begin
                lat = n;
                rd  = dat_o;
                break;
            end
        end
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
    endtask

    task automatic wait_delivered(input int n, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (delivered >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    initial begin
        logic [7:0] rd;
        int         lat;
        logic       ok;
        logic [7:0] exp_b [6];

        rst = 1'b1; cyc_i = 0; stb_i = 0; we_i = 0; bst_i = 0; adr_i = '0; dat_i = '0; spi_busy = 0;
        repeat (3) tick();
        report("rst_ack", ack_o === 1'b0, 32'(ack_o), 32'h0);
        report("rst_wat", wat_o === 1'b0, 32'(wat_o), 32'h0);
        report("rst_dat", dat_o === 8'h00, 32'(dat_o), 32'h0);
        report("rst_req", data_request === 1'b0, 32'(data_request), 32'h0);
        report("rst_en", aq_enabled === 1'b0, 32'(aq_enabled), 32'h0);
        rst = 1'b0;

        // Registers after reset
        bus(0, ADR_CONTROL, 8'h00, rd, lat);
        report("ctl_lat", lat == 1, 32'(lat), 32'd1);
        report("ctl_rd", rd === 8'h00, 32'(rd), 32'h00);
        bus(0, ADR_STATUS, 8'h00, rd, lat);
        report("status_rd", rd === 8'h01, 32'(rd), 32'h01);
        spi_busy = 1'b1;
        bus(0, ADR_STATUS, 8'h00, rd, lat);
        report("status_spi", rd === 8'h81, 32'(rd), 32'h81);
        spi_busy = 1'b0;
        bus(1, ADR_DATA, 8'h55, rd, lat);
        report("wr_data_lat", lat == 1, 32'(lat), 32'd1);
        bus(0, ADR_LEVEL, 8'h00, rd, lat);
        report("level_idle", rd === 8'h00, 32'(rd), 32'h00);
        bus(1, ADR_CONTROL, 8'hFE, rd, lat);
        bus(0, ADR_CONTROL, 8'h00, rd, lat);
        report("ctl_mask", rd === 8'h1E, 32'(rd), 32'h1E);
        report("ctl_dbg", aq_debug_mode === 1'b1, 32'(aq_debug_mode), 32'h1);
        report("ctl_dly", aq_sample_delay === 3'd7, 32'(aq_sample_delay), 32'h7);
        report("ctl_en_off", aq_enabled === 1'b0, 32'(aq_enabled), 32'h0);
        report("no_req_idle", req_cnt == 0, 32'(req_cnt), 32'd0);

        // Prefetch: two samples, then hold the source
        src_gate = 1'b1;
        bus(1, ADR_CONTROL, 8'h01, rd, lat);
        report("en_lat", lat == 1, 32'(lat), 32'd1);
        wait_delivered(2, ok);
        src_gate = 1'b0;
        report("wait_two", ok === 1'b1, 32'(ok), 32'h1);
        repeat (4) tick();
        bus(0, ADR_LEVEL, 8'h00, rd, lat);
        report("level_two", rd === 8'h02, 32'(rd), 32'h02);
        report("req_three", req_cnt == 3, 32'(req_cnt), 32'd3);
        src_gate = 1'b1;
        wait_delivered(4, ok);
        report("wait_four", ok === 1'b1, 32'(ok), 32'h1);
        repeat (6) tick();
        src_gate = 1'b0;
        report("req_full_stop", req_cnt == 4, 32'(req_cnt), 32'd4);
        report("no_overlap", overlap == 0, 32'(overlap), 32'd0);
        bus(0, ADR_LEVEL, 8'h00, rd, lat);
        report("level_full", rd === 8'h04, 32'(rd), 32'h04);
        bus(0, ADR_STATUS, 8'h00, rd, lat);
        report("status_full", rd === 8'h02, 32'(rd), 32'h02);

        // Burst read across sample boundary
        exp_b = '{8'hA1, 8'hB2, 8'hC3, 8'h44, 8'h55, 8'h66};
        tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; bst_i = 1'b1; adr_i = ADR_DATA;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                tick();
                report("burst_ack_drop", ack_o === 1'b0, 32'(ack_o), 32'h0);
            end
            tick();
            report("burst_ack", ack_o === 1'b1, 32'(ack_o), 32'h1);
            report("burst_dat", dat_o === exp_b[i], 32'(dat_o), 32'(exp_b[i]));
        end
        cyc_i = 1'b0; stb_i = 1'b0; bst_i = 1'b0;
        #1;
        report("ack_gated_cyc", ack_o === 1'b0, 32'(ack_o), 32'h0);
        bus(0, ADR_LEVEL, 8'h00, rd, lat);
        report("level_after_pop", rd === 8'h03, 32'(rd), 32'h03);
        tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; bst_i = 1'b1; adr_i = ADR_DATA;
        for (int i = 4; i < 6; i++) begin
            if (i > 4) tick();
            tick();
            report("burst2_ack", ack_o === 1'b1, 32'(ack_o), 32'h1);
            report("burst2_dat", dat_o === exp_b[i], 32'(dat_o), 32'(exp_b[i]));
        end
        cyc_i = 1'b0; stb_i = 1'b0; bst_i = 1'b0;
        bus(0, ADR_LEVEL, 8'h00, rd, lat);
        report("level_two_left", rd === 8'h02, 32'(rd), 32'h02);

        // Drain the remaining two samples
        exp_b = '{8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
        for (int i = 0; i < 6; i++) begin
            bus(0, ADR_DATA, 8'h00, rd, lat);
            report("drain_lat", lat == 1, 32'(lat), 32'd1);
            report("drain_dat", rd === exp_b[i], 32'(rd), 32'(exp_b[i]));
        end
        bus(0, ADR_STATUS, 8'h00, rd, lat);
        report("status_empty", rd === 8'h01, 32'(rd), 32'h01);

        // Wait state on empty FIFO while enabled
        tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = ADR_DATA;
        tick();
        report("wait_wat", wat_o === 1'b1, 32'(wat_o), 32'h1);
        report("wait_noack", ack_o === 1'b0, 32'(ack_o), 32'h0);
        tick();
        tick();
        report("wait_hold", wat_o === 1'b1, 32'(wat_o), 32'h1);
        src_gate = 1'b1;
        tick();
        report("wait_ack", ack_o === 1'b1, 32'(ack_o), 32'h1);
        report("wait_dat", dat_o === 8'h12, 32'(dat_o), 32'h12);
        report("wait_release", wat_o === 1'b0, 32'(wat_o), 32'h0);
        cyc_i = 1'b0; stb_i = 1'b0;

        // Flush with three samples buffered, then underrun
        wait_delivered(7, ok);
        src_gate = 1'b0;
        report("wait_seven", ok === 1'b1, 32'(ok), 32'h1);
        bus(0, ADR_LEVEL, 8'h00, rd, lat);
        report("level_three", rd === 8'h03, 32'(rd), 32'h03);
        bus(1, ADR_CONTROL, 8'h00, rd, lat);
        report("dis_en", aq_enabled === 1'b0, 32'(aq_enabled), 32'h0);
        bus(0, ADR_LEVEL, 8'h00, rd, lat);
        report("level_flushed", rd === 8'h00, 32'(rd), 32'h00);
        bus(0, ADR_DATA, 8'h00, rd, lat);
        report("underrun_lat", lat == 1, 32'(lat), 32'd1);
        report("underrun_dat", rd === 8'h00, 32'(rd), 32'h00);
        bus(0, ADR_STATUS, 8'h00, rd, lat);
        report("status_underrun", rd === 8'h05, 32'(rd), 32'h05);
        bus(1, ADR_STATUS, 8'h04, rd, lat);
        bus(0, ADR_STATUS, 8'h00, rd, lat);
        report("status_w1c", rd === 8'h01, 32'(rd), 32'h01);

        // Reset in the middle of a burst with byte index 1
        src_gate = 1'b1;
        bus(1, ADR_CONTROL, 8'h01, rd, lat);
        wait_delivered(9, ok);
        src_gate = 1'b0;
        report("wait_nine", ok === 1'b1, 32'(ok), 32'h1);
        tick();
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; bst_i = 1'b1; adr_i = ADR_DATA;
        tick();
        report("rb_ack", ack_o === 1'b1, 32'(ack_o), 32'h1);
        report("rb_dat", dat_o === 8'h34, 32'(dat_o), 32'h34);
        tick();
        rst = 1'b1;
        tick();
        report("rst_mid_ack", ack_o === 1'b0, 32'(ack_o), 32'h0);
        report("rst_mid_dat", dat_o === 8'h00, 32'(dat_o), 32'h00);
        rst = 1'b0;
        cyc_i = 1'b0; stb_i = 1'b0; bst_i = 1'b0;
        bus(0, ADR_LEVEL, 8'h00, rd, lat);
        report("rst_level", rd === 8'h00, 32'(rd), 32'h00);
        bus(0, ADR_CONTROL, 8'h00, rd, lat);
        report("rst_ctl", rd === 8'h00, 32'(rd), 32'h00);
        src_gate = 1'b1;
        bus(1, ADR_CONTROL, 8'h01, rd, lat);
        wait_delivered(10, ok);
        report("wait_ten", ok === 1'b1, 32'(ok), 32'h1);
        bus(0, ADR_DATA, 8'h00, rd, lat);
        report("post_rst_lat", lat == 1, 32'(lat), 32'd1);
        report("post_rst_msb", rd === 8'h9A, 32'(rd), 32'h9A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
